// File: rtl/d_latch_pkg.sv
// Shared sizing and lane-indexing helpers for the d_latch storage element.
// The top level and its lane instances both import this package.
package d_latch_pkg;

    // Number of enable lanes for a given data width and lane width.
    function automatic int nlanes(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    // Bit position of the LSB of lane i, used to slice data with +: lane_w.
    function automatic int lane_lsb(input int i, input int lane_w);
        return i * lane_w;
    endfunction

endpackage

// File: rtl/d_latch_lane.sv
// One enable lane: a clocked hold register plus a transparent output mux.
// Reset overrides the transparent path so q is clean while rst_n is low.
module d_latch_lane #(
    parameter int                LANE_W    = 1,
    parameter logic [LANE_W-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [LANE_W-1:0] i_val,
    output logic [LANE_W-1:0] o_q,
    output logic              o_changed
);

    logic [LANE_W-1:0] r_hold;
    logic              r_changed;
    logic              w_diff;

    // Gate the compare with the enable so an X on a disabled lane never leaks.
    assign w_diff = i_en && (i_val != r_hold);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= RESET_VAL;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_diff;
            if (i_en) begin
                r_hold <= i_val;
            end
        end
    end

    always_comb begin
        o_q = r_hold;
        if (!i_rst_n) begin
            o_q = RESET_VAL;
        end else if (i_en) begin
            o_q = i_val;
        end
    end

    assign o_changed = r_changed;

endmodule

// File: rtl/d_latch.sv
// Multi-bit, per-lane transparent latch built from flops and muxes.
// Adds a sticky valid flag and a one-cycle change pulse.
module d_latch
    import d_latch_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               LANE_W    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              NLANES    = nlanes(WIDTH, LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NLANES-1:0] en,
    input  logic [WIDTH-1:0]  val,
    output logic [WIDTH-1:0]  q,
    output logic              q_valid,
    output logic              q_changed
);

    logic [NLANES-1:0] w_changed;
    logic              r_valid;

    if ((WIDTH % LANE_W) != 0) begin : g_bad_cfg
        $error("d_latch: WIDTH must be an integer multiple of LANE_W");
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        d_latch_lane #(
            .LANE_W    (LANE_W),
            .RESET_VAL (RESET_VAL[lane_lsb(g, LANE_W) +: LANE_W])
        ) u_lane (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_en      (en[g]),
            .i_val     (val[lane_lsb(g, LANE_W) +: LANE_W]),
            .o_q       (q[lane_lsb(g, LANE_W) +: LANE_W]),
            .o_changed (w_changed[g])
        );
    end

    // Sticky: once any lane has been open across an edge, data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid | (|en);
        end
    end

    assign q_valid   = r_valid;
    assign q_changed = |w_changed;

    a_en_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(en));

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a scalar instance and an 8-bit/4-bit-lane instance.
// Expected values are queued as stimulus is applied and popped at each sample.
module tb_d_latch;

    localparam int W = 8;

    logic clk;

    // scalar instance
    logic       s_rst_n;
    logic [0:0] s_en;
    logic [0:0] s_val;
    logic [0:0] s_q;
    logic       s_qv;
    logic       s_qc;

    // lane instance
    logic       l_rst_n;
    logic [1:0] l_en;
    logic [7:0] l_val;
    logic [7:0] l_q;
    logic       l_qv;
    logic       l_qc;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    d_latch u_s (
        .clk       (clk),
        .rst_n     (s_rst_n),
        .en        (s_en),
        .val       (s_val),
        .q         (s_q),
        .q_valid   (s_qv),
        .q_changed (s_qc)
    );

    d_latch #(.WIDTH(8), .LANE_W(4)) u_l (
        .clk       (clk),
        .rst_n     (l_rst_n),
        .en        (l_en),
        .val       (l_val),
        .q         (l_q),
        .q_valid   (l_qv),
        .q_changed (l_qc)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard
    task automatic push(input logic [W-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    // drivers
    task automatic s_drive(input logic en, input logic v);
        s_en  = en;
        s_val = v;
    endtask

    task automatic l_drive(input logic [1:0] en, input logic [7:0] v);
        l_en  = en;
        l_val = v;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        s_rst_n = 1'b0;
        l_rst_n = 1'b0;
        s_drive(1'b1, 1'b1);
        l_drive(2'b00, 8'h00);

        // ---------------- scalar: reset dominates transparency
        neg(); neg();
        push(8'h0); check("s_rst_q", W'(s_q));
        push(8'h0); check("s_rst_qv", W'(s_qv));
        push(8'h0); check("s_rst_qc", W'(s_qc));

        // release: transparent immediately, then close before any edge
        s_rst_n = 1'b1;
        #1;
        push(8'h1); check("s_rel_transp", W'(s_q));
        s_drive(1'b0, 1'b1);
        #1;
        push(8'h0); check("s_rel_closed", W'(s_q));

        // en=0: q holds RESET_VAL regardless of val
        neg();
        push(8'h0); check("s_dis_qv", W'(s_qv));
        s_drive(1'b0, 1'b0); #1;
        push(8'h0); check("s_dis_v0", W'(s_q));
        s_drive(1'b0, 1'b1); #1;
        push(8'h0); check("s_dis_v1", W'(s_q));
        s_drive(1'b0, 1'bx); #1;
        push(8'h0); check("s_dis_vx", W'(s_q));
        neg();
        push(8'h0); check("s_dis_vx_qc", W'(s_qc));

        // en=1: transparent, then capture on the edge
        s_drive(1'b1, 1'b0); #1;
        push(8'h0); check("s_en_v0", W'(s_q));
        s_drive(1'b1, 1'b1); #1;
        push(8'h1); check("s_en_v1", W'(s_q));
        neg();
        push(8'h1); check("s_cap_qc", W'(s_qc));
        push(8'h1); check("s_cap_qv", W'(s_qv));
        s_drive(1'b0, 1'b0); #1;
        push(8'h1); check("s_close_q", W'(s_q));
        neg();
        push(8'h0); check("s_hold_qc", W'(s_qc));
        push(8'h1); check("s_hold_q", W'(s_q));

        // reload 0 so the short-pulse test has a known old value
        s_drive(1'b1, 1'b0);
        neg();
        push(8'h1); check("s_reload_qc", W'(s_qc));
        s_drive(1'b0, 1'b0);
        neg();

        // short enable not spanning a rising edge
        s_drive(1'b1, 1'b1); #1;
        push(8'h1); check("s_pulse_q", W'(s_q));
        #1;
        s_drive(1'b0, 1'b1); #1;
        push(8'h0); check("s_pulse_revert", W'(s_q));
        neg();
        push(8'h0); check("s_pulse_hold", W'(s_q));
        push(8'h0); check("s_pulse_qc", W'(s_qc));

        // ---------------- lanes: WIDTH=8, LANE_W=4
        l_rst_n = 1'b1;
        #1;
        push(8'h00); check("l_init_q", l_q);
        push(8'h00); check("l_init_qv", W'(l_qv));
        neg();

        l_drive(2'b01, 8'hAB); #1;
        push(8'h0B); check("l_lane0_transp", l_q);
        neg();
        push(8'h1); check("l_lane0_qc", W'(l_qc));
        push(8'h1); check("l_lane0_qv", W'(l_qv));
        l_drive(2'b00, 8'hAB); #1;
        push(8'h0B); check("l_lane0_hold", l_q);

        // identical rewrite: no change pulse
        l_drive(2'b01, 8'h0B);
        neg();
        push(8'h0); check("l_same_qc", W'(l_qc));
        push(8'h0B); check("l_same_q", l_q);

        // upper lane open, lower lane holds
        l_drive(2'b10, 8'hC5); #1;
        push(8'hCB); check("l_lane1_transp", l_q);

        // disabled lower lane driven with X must not leak
        l_drive(2'b10, {4'h7, 4'bxxxx}); #1;
        push(8'h7B); check("l_xlane_q", l_q);
        neg();
        push(8'h1); check("l_xlane_qc", W'(l_qc));
        l_drive(2'b00, 8'h00); #1;
        push(8'h7B); check("l_xlane_hold", l_q);

        // load all ones, then reset between edges
        l_drive(2'b11, 8'hFF);
        neg();
        l_drive(2'b00, 8'h00); #1;
        push(8'hFF); check("l_ff_hold", l_q);
        #1;
        l_rst_n = 1'b0; #1;
        push(8'h00); check("l_midrst_q", l_q);
        push(8'h0); check("l_midrst_qv", W'(l_qv));
        push(8'h0); check("l_midrst_qc", W'(l_qc));

        // reset held with lanes open: reset still wins
        l_drive(2'b11, 8'h5A); #1;
        push(8'h00); check("l_rst_dominant", l_q);
        neg();
        l_drive(2'b00, 8'h00);
        l_rst_n = 1'b1; #1;
        push(8'h00); check("l_rel_q", l_q);

        // first edge after release operates normally
        l_drive(2'b01, 8'h03);
        neg();
        l_drive(2'b00, 8'h00); #1;
        push(8'h1); check("l_post_qc", W'(l_qc));
        push(8'h1); check("l_post_qv", W'(l_qv));
        push(8'h03); check("l_post_q", l_q);
        neg();
        push(8'h0); check("l_post_qc_drop", W'(l_qc));
        push(8'h1); check("l_post_qv_sticky", W'(l_qv));

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
